// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
// Shared definitions for the two-bank (A/B) ping-pong frame buffer controller.
//   bank_state_t : per-bank lifecycle EMPTY -> FILLING -> FULL -> READING -> EMPTY
//   BANK_A/BANK_B: bank index encoding used by the write and read pointers
//   is_writable  : true when a bank can still take writer data
// -----------------------------------------------------------------------------
package pingpong_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  function automatic logic is_writable(input bank_state_t s);
    return (s == EMPTY) || (s == FILLING);
  endfunction

endpackage

// File: rtl/pingpong_bank_fsm.sv
// -----------------------------------------------------------------------------
// pingpong_bank_fsm
// Lifecycle state of one frame bank.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (bank returns to EMPTY)
//   fill_word  : a writer word is accepted into this bank this cycle
//   fill_last  : qualifies fill_word; the accepted word completes the frame
//   start      : reader takes this bank (honoured only when FULL)
//   done       : reader releases this bank (honoured only when READING)
//   state      : current bank state
// Each event is only honoured in the state it belongs to, so a stray strobe in
// the wrong state has no effect.
// -----------------------------------------------------------------------------
module pingpong_bank_fsm
  import pingpong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_word,
  input  logic        fill_last,
  input  logic        start,
  input  logic        done,
  output bank_state_t state
);

  bank_state_t state_q;
  bank_state_t state_d;

  always_comb begin
    // NOTE: hold-value default first so every path assigns state_d; without it
    // the unhandled cases would infer a latch.
    state_d = state_q;
    case (state_q)
      EMPTY, FILLING: if (fill_word) state_d = fill_last ? FULL : FILLING;
      FULL:           if (start)     state_d = READING;
      READING:        if (done)      state_d = EMPTY;
      default:                       state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values; reset is asynchronous and in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_ctrl
// Ping-pong frame buffer controller: write addressing and bank select toward
// the write demux, per-bank fill tracking, and hand-off of full banks to the
// downstream reader.
// Parameters:
//   ADDR_WIDTH  : bank address width
//   FRAME_WORDS : words per frame (1 .. 2**ADDR_WIDTH)
//   CNT_WIDTH   : completed-frame counter width
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   wr_valid / wr_ready   : writer handshake; ready drops only when the
//                           write-target bank is FULL or READING
//   wr_en, wr_addr        : combinational write strobe and address to demux
//   A_select, B_select    : one-hot write-target bank select
//   rd_valid, rd_bank_sel : full bank offered to / held by the reader
//   rd_start, rd_done     : reader takes / releases the bank at rd_bank_sel
//   frame_cnt             : frames completed by the writer (wraps)
// -----------------------------------------------------------------------------
module pingpong_ctrl
  import pingpong_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int FRAME_WORDS = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  A_select,
  output logic                  B_select,
  output logic                  rd_valid,
  output logic                  rd_bank_sel,
  input  logic                  rd_start,
  input  logic                  rd_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

  logic                  wr_bank_q,   wr_bank_d;
  logic                  rd_bank_q,   rd_bank_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q,  word_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

  bank_state_t state_a, state_b;
  bank_state_t wr_state, rd_state;

  logic accept_last;
  logic rd_start_ok;
  logic rd_done_ok;

  assign wr_state = (wr_bank_q == BANK_B) ? state_b : state_a;
  assign rd_state = (rd_bank_q == BANK_B) ? state_b : state_a;

  // Write path is purely combinational from registered state so the strobe
  // lines up with data passing through the demux in the same cycle.
  assign wr_ready    = is_writable(wr_state);
  assign wr_en       = wr_valid & wr_ready;
  assign accept_last = wr_en & (word_cnt_q == LAST_WORD);

  // Reader strobes are only meaningful in the matching state; a cycle with both
  // asserted therefore acts on whichever one the current state accepts.
  assign rd_start_ok = rd_start & (rd_state == FULL);
  assign rd_done_ok  = rd_done  & (rd_state == READING);

  pingpong_bank_fsm u_bank_a (
    .clk       (clk),
    .rst       (rst),
    .fill_word (wr_en       & (wr_bank_q == BANK_A)),
    .fill_last (accept_last),
    .start     (rd_start_ok & (rd_bank_q == BANK_A)),
    .done      (rd_done_ok  & (rd_bank_q == BANK_A)),
    .state     (state_a)
  );

  pingpong_bank_fsm u_bank_b (
    .clk       (clk),
    .rst       (rst),
    .fill_word (wr_en       & (wr_bank_q == BANK_B)),
    .fill_last (accept_last),
    .start     (rd_start_ok & (rd_bank_q == BANK_B)),
    .done      (rd_done_ok  & (rd_bank_q == BANK_B)),
    .state     (state_b)
  );

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (wr_en) begin
      if (accept_last) begin
        word_cnt_d  = '0;
        wr_bank_d   = ~wr_bank_q;
        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      end else begin
        word_cnt_d  = word_cnt_q + ADDR_WIDTH'(1);
      end
    end

    if (rd_done_ok) rd_bank_d = ~rd_bank_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= BANK_A;
      rd_bank_q   <= BANK_A;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign wr_addr     = word_cnt_q;
  assign A_select    = (wr_bank_q == BANK_A);
  assign B_select    = (wr_bank_q == BANK_B);
  assign rd_valid    = (rd_state == FULL);
  assign rd_bank_sel = rd_bank_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/pingpong_ctrl.md
# pingpong_ctrl

Controller for the two-bank (A/B) ping-pong frame buffer in the filter pipeline. Sits between the pixel/feature writer, the write demux and the downstream reader. It generates write enable and address, drives the A/B bank selects into the write demux, tracks per-bank fill state, and hands completed banks to the reader. The writer is back-pressured only when both banks are occupied.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8. Bank address width, matching the write demux.
- `FRAME_WORDS`, default 256. Words per frame. Legal range is 1..2**ADDR_WIDTH.
- `CNT_WIDTH`, default 16. Width of the completed-frame counter.

Ports:
- `clk` in 1. Single clock.
- `rst` in 1. Asynchronous, active-high reset.
- `wr_valid` in 1. Writer presents a data word this cycle.
- `wr_ready` out 1. Controller can accept a word.
- `wr_en` out 1. Write strobe to demux `wr_en_in`.
- `wr_addr` out ADDR_WIDTH. Write address to demux `addr_in`.
- `A_select` out 1. Bank A is the write target.
- `B_select` out 1. Bank B is the write target.
- `rd_valid` out 1. A full bank is waiting for the reader.
- `rd_bank_sel` out 1. Bank offered to or held by the reader: 0 = A, 1 = B.
- `rd_start` in 1. Reader accepts the offered bank.
- `rd_done` in 1. Reader has finished the held bank; the bank is released.
- `frame_cnt` out CNT_WIDTH. Count of frames completed by the writer; wraps.

## Operation
- Each bank has its own state machine with states EMPTY, FILLING, FULL and READING.
- Pointers and counters:
  - `wr_bank` is the write-target bank.
  - `rd_bank` is the next bank to read.
  - `word_cnt` counts words 0..FRAME_WORDS-1 within the current frame.
- Write-side signals:
  - `wr_ready` = state[wr_bank] ∈ {EMPTY, FILLING}. It is combinational from registered state.
  - `wr_en` = wr_valid & wr_ready. It is combinational, so it stays aligned with the unregistered data path through the demux.
  - `wr_addr` = word_cnt.
  - `A_select` = (wr_bank == 0); `B_select` = (wr_bank == 1). Exactly one is high at all times, including while stalled.
- On an accepted word that is not the last word:
  - state[wr_bank] → FILLING.
  - word_cnt increments.
- On an accepted last word (word_cnt == FRAME_WORDS-1):
  - state[wr_bank] → FULL.
  - word_cnt → 0.
  - wr_bank toggles.
  - frame_cnt increments, wrapping modulo 2**CNT_WIDTH.
- Read-side signals:
  - `rd_valid` = (state[rd_bank] == FULL).
  - `rd_bank_sel` = rd_bank.
- `rd_start` while rd_valid moves rd_bank to READING. `rd_start` at any other time is ignored.
- `rd_done` while state[rd_bank] == READING:
  - rd_bank → EMPTY.
  - rd_bank toggles.
  - `rd_done` at any other time is ignored.
- `rd_start` and `rd_done` asserted in the same cycle act on the current state only. FULL takes the start; READING takes the done.
- Simultaneous write completion and read release always target different banks, and both take effect in the same edge.
- When both banks are FULL or READING, `wr_ready` = 0 and writes stall. There is no drop and no overwrite.
- Frames are delivered to the reader in write order; the read sequence is A, B, A, ...

## Timing
- Reset values (asynchronous, applied immediately on `rst`):
  - both banks EMPTY; wr_bank = 0; rd_bank = 0; word_cnt = 0; frame_cnt = 0.
  - Resulting outputs: wr_ready = 1, wr_en = 0, wr_addr = 0, A_select = 1, B_select = 0, rd_valid = 0, rd_bank_sel = 0.
- Reset mid-frame discards the partial frame and any full or held bank. The reader must treat reset as an abort.
- Write path has zero latency: `wr_en` and `wr_addr` are valid in the same cycle as `wr_valid`.
- Bank completion to reader:
  - The last word is accepted at edge N.
  - `rd_valid` is high in cycle N+1, if that bank is the read pointer.
  - A/B selects switch in cycle N+1.
- Bank release to writer:
  - `rd_done` is sampled at edge N.
  - `wr_ready` for that bank is high in cycle N+1.
- For FRAME_WORDS = 1, every accepted word completes a frame.

## Structure
- Shared package `pingpong_pkg` holds:
  - `bank_state_t` enum: EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, READING = 2'd3.
  - Bank index constants BANK_A = 1'b0 and BANK_B = 1'b1.
- Sub-module `pingpong_bank_fsm`, instantiated twice. It holds one bank's state register, with inputs fill_word, fill_last, start and done, and outputs the bank state.
- The top level holds wr_bank, rd_bank, word_cnt, frame_cnt and the output muxing.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs at their listed reset values. A_select = 1 and B_select = 0 throughout.
- **Fill A** (FRAME_WORDS = 4): wr_valid held for 4 cycles.
  - → wr_en = 1 with wr_addr 0, 1, 2, 3 and A_select = 1.
  - Next cycle → B_select = 1, rd_valid = 1, rd_bank_sel = 0, frame_cnt = 1.
- **Back-pressure:** fill A, then fill B with no reader activity, then keep wr_valid high.
  - → wr_ready = 0 and wr_en = 0.
  - frame_cnt holds at 2.
  - rd_bank_sel = 0.
- **Release and refill:**
  - rd_start → rd_valid = 0.
  - rd_done → wr_ready = 1 with A_select = 1 next cycle, and rd_valid = 1 with rd_bank_sel = 1.
- **Simultaneous events:**
  - Writer's last word into B in the same cycle as rd_done for A → next cycle: A EMPTY (wr_ready = 1, A_select = 1), B FULL (rd_valid = 1, rd_bank_sel = 1).
  - Illegal strobes: rd_done without a prior rd_start, and rd_start with rd_valid = 0 → both ignored.
- **Async reset mid-frame:** assert `rst` with word_cnt = 2 and bank B FULL → outputs return to reset values without a clock edge. The next write goes to A at wr_addr = 0.
